dtc_walk_ctrl: RTL and testbench

Sequential, table-driven decision-tree evaluator and controller. It replaces hard-wired combinational tree classifiers with a programmable node table and walks that table one node per cycle from root to leaf. Input feature vectors arrive over a valid/ready stream. Each result is the leaf's thermometer-coded class word (e.g. 11'b00000111111). Sits between the feature-extraction stage and the downstream class consumer; the node table is loaded by the configuration host.

---
 rtl/dtc_walk_ctrl.sv | 150 +++++++++++++++
 tb/tb_dtc_walk_ctrl.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dtc_walk_ctrl
// Description : Table-driven decision-tree evaluator. The node table is held in
//               a 2**AW x ENTRY_W register file. Each accepted feature vector
//               walks the table from the root (address 0), reading one node per
//               cycle, until it reaches a leaf. The result is that leaf's
//               class word.
//               A walk that keeps hitting internal nodes is aborted once
//               MAX_DEPTH internal nodes have been traversed, and it then
//               reports an error.
// Ports       : clk, rst             - clock and asynchronous active-high reset
//               cfg_we/addr/wdata    - node table write port (only taken while idle)
//               busy                 - controller is not idle
//               in_valid/ready/data  - feature vector stream
//               out_valid/ready      - result handshake
//               out_data             - leaf class word (0 on error)
//               out_depth            - internal nodes traversed
//               out_err              - walk aborted at MAX_DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module dtc_walk_ctrl #(
    parameter int IN_W      = 11,
    parameter int OUT_W     = 11,
    parameter int AW        = 6,
    parameter int FW        = 4,
    parameter int MAX_DEPTH = 8,   // must fit the 4-bit out_depth
    parameter int ENTRY_W   = 1 + (((FW + 2*AW) > OUT_W) ? (FW + 2*AW) : OUT_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [ENTRY_W-1:0] cfg_wdata,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [3:0]         out_depth,
    output logic               out_err
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WALK      = 2'd1;
    localparam logic [1:0] c_DONE      = 2'd2;
    localparam int         c_NODES     = 2**AW;
    localparam logic [3:0] c_MAX_DEPTH = 4'(MAX_DEPTH);

    logic [1:0]         r_state;
    logic [AW-1:0]      r_ptr;
    logic [3:0]         r_depth;
    logic [IN_W-1:0]    r_data;
    logic [ENTRY_W-1:0] r_table [c_NODES];

    logic [ENTRY_W-1:0] w_entry;
    logic               w_leaf;
    logic [FW-1:0]      w_fidx;
    logic [AW-1:0]      w_true;
    logic [AW-1:0]      w_false;
    logic [2**FW-1:0]   w_fvec;
    logic               w_fbit;

    assign busy     = (r_state != c_IDLE);
    assign in_ready = (r_state == c_IDLE);

    // The node table is deliberately left out of reset so that a programmed
    // tree survives a reset. Writes are only honoured while idle, so the table
    // never changes under a walk in progress. A write that lands on the same
    // edge as an accept is still visible to the first WALK read.
    always_ff @(posedge clk) begin
        if (cfg_we && (r_state == c_IDLE)) begin
            r_table[cfg_addr] <= cfg_wdata;
        end
    end

    // Decode the node at the current pointer
    assign w_entry = r_table[r_ptr];
    assign w_leaf  = w_entry[ENTRY_W-1];
    assign w_fidx  = w_entry[FW+2*AW-1:2*AW];
    assign w_true  = w_entry[2*AW-1:AW];
    assign w_false = w_entry[AW-1:0];

    // Zero-extend the feature vector to the full index range. Feature indices
    // at or above IN_W then read as 0 without a separate range compare.
    always_comb begin
        w_fvec            = '0;
        w_fvec[IN_W-1:0]  = r_data;
    end
    assign w_fbit = w_fvec[w_fidx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_ptr     <= '0;
            r_depth   <= '0;
            r_data    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_depth <= '0;
            out_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_ptr   <= '0;
                        r_depth <= '0;
                        r_state <= c_WALK;
                    end
                end
                c_WALK: begin
                    if (w_leaf) begin
                        out_data  <= w_entry[OUT_W-1:0];
                        out_depth <= r_depth;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        r_state   <= c_DONE;
                    end else if (r_depth == c_MAX_DEPTH) begin
                        // Another internal node after MAX_DEPTH hops means
                        // the table loops or is too deep, so the walk is abandoned.
                        out_data  <= '0;
                        out_depth <= c_MAX_DEPTH;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= c_DONE;
                    end else begin
                        r_ptr   <= w_fbit ? w_true : w_false;
                        r_depth <= r_depth + 4'd1;
                    end
                end
                c_DONE: begin
                    // Return to IDLE first, so a new vector is only accepted
                    // on the following cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dtc_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtc_walk_ctrl
// Description : Self-checking bench for dtc_walk_ctrl. Results are compared
//               against a behavioural tree walk over a bench-side copy of the
//               node table, and for the full 4-level tree against a closed-form
//               golden classifier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtc_walk_ctrl;

    localparam int c_IN_W  = 11;
    localparam int c_OUT_W = 11;
    localparam int c_AW    = 6;
    localparam int c_EW    = 17;
    localparam int c_MAXD  = 8;

    logic                clk;
    logic                rst;
    logic                cfg_we;
    logic [c_AW-1:0]     cfg_addr;
    logic [c_EW-1:0]     cfg_wdata;
    logic                busy;
    logic                in_valid;
    logic                in_ready;
    logic [c_IN_W-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [c_OUT_W-1:0]  out_data;
    logic [3:0]          out_depth;
    logic                out_err;

    int n_vec = 0;
    int n_err = 0;

    logic [c_EW-1:0] mdl [64];

    int              inj_cyc  = -1;
    logic [c_AW-1:0] inj_addr = '0;
    logic [c_EW-1:0] inj_data = '0;

    dtc_walk_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_depth (out_depth),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // Reference walk: follow the rules node by node over the model table.
    function automatic void model_walk(input logic [c_IN_W-1:0] d,
                                       output logic [c_OUT_W-1:0] cls,
                                       output int dep, output logic err);
        int ptr;
        ptr = 0;
        cls = '0; dep = 0; err = 1'b0;
        for (int k = 0; k <= c_MAXD; k++) begin
            logic [c_EW-1:0] e;
            int f;
            e = mdl[ptr];
            dep = k;
            if (e[16]) begin
                cls = e[10:0];
                return;
            end
            if (k == c_MAXD) begin
                err = 1'b1;
                return;
            end
            f = int'(e[15:12]);
            if (f < c_IN_W && d[f]) ptr = int'(e[11:6]);
            else                    ptr = int'(e[5:0]);
        end
    endfunction

    // Closed-form golden for the 4-level tree: path bits {f6,f1,f7,f5}.
    function automatic logic [c_OUT_W-1:0] tree_class(input int idx);
        int n;
        n = (idx % 8) + (idx / 8) * 3 + 1;
        return c_OUT_W'((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [c_OUT_W-1:0] tree_gold(input logic [c_IN_W-1:0] d);
        int idx;
        idx = {28'd0, d[6], d[1], d[7], d[5]};
        return tree_class(idx);
    endfunction

    task automatic cfg_write(input logic [c_AW-1:0] a, input logic [c_EW-1:0] v);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = v;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mdl[a] = v;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    // Drives one vector, captures the result and handshakes it after `hold`
    // stall cycles. Latency is counted so that the accept cycle is 0.
    task automatic do_walk(input logic [c_IN_W-1:0] d, input int hold,
                           output logic [c_OUT_W-1:0] od, output logic [3:0] odep,
                           output logic oe, output int lat, output bit stable,
                           output bit rdy_low, output bit rdy_after);
        stable = 1'b1; rdy_low = 1'b1; rdy_after = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        if (inj_cyc == 0) begin
            cfg_we = 1'b1; cfg_addr = inj_addr; cfg_wdata = inj_data;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = c_IN_W'($urandom);
        cfg_we = 1'b0;
        if (inj_cyc == 1) begin
            cfg_we = 1'b1; cfg_addr = inj_addr; cfg_wdata = inj_data;
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_low = 1'b0;
            @(posedge clk); #1;
            cfg_we = 1'b0;
            lat++;
        end
        cfg_we = 1'b0;
        od = out_data; odep = out_depth; oe = out_err;
        if (hold > 0) begin
            in_valid = 1'b1; in_data = c_IN_W'($urandom);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || out_data !== od || out_depth !== odep || out_err !== oe)
                    stable = 1'b0;
                if (in_ready !== 1'b0) rdy_low = 1'b0;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rdy_after = (in_ready === 1'b1);
        in_valid  = 1'b0;
        if (busy) drain();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_depth !== 4'd0 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h dep=%0d e=%b want 0 0 0 0",
                     out_valid, out_data, out_depth, out_err);
        end
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_status: got busy=%b ready=%b want busy=0 ready=1", busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b busy=%b valid=%b want 1 0 0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [c_OUT_W-1:0] od, ecls;
        logic [3:0] odep;
        logic oe, eerr;
        int lat, edep;
        bit st, rl, ra;
        cfg_write(6'd0, 17'h06081);
        cfg_write(6'd1, 17'h100FF);
        cfg_write(6'd2, 17'h1003F);
        do_walk(11'h040, 0, od, odep, oe, lat, st, rl, ra);
        n_vec++;
        if (od !== 11'h03F || odep !== 4'd1 || oe !== 1'b0 || lat != 3) begin
            n_err++;
            $display("FAIL basic_040: got d=%h dep=%0d e=%b lat=%0d want 03f 1 0 3", od, odep, oe, lat);
        end
        n_vec++;
        if (rl !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: got in_ready/busy wrong during walk=%b want 1", rl);
        end
        do_walk(11'h000, 0, od, odep, oe, lat, st, rl, ra);
        n_vec++;
        if (od !== 11'h0FF || odep !== 4'd1 || oe !== 1'b0 || lat != 3) begin
            n_err++;
            $display("FAIL basic_000: got d=%h dep=%0d e=%b lat=%0d want 0ff 1 0 3", od, odep, oe, lat);
        end
        for (int i = 0; i < 6; i++) begin
            logic [c_IN_W-1:0] d;
            d = c_IN_W'($urandom);
            model_walk(d, ecls, edep, eerr);
            do_walk(d, 0, od, odep, oe, lat, st, rl, ra);
            n_vec++;
            if (od !== ecls || odep !== 4'(edep) || oe !== eerr || lat != edep + 2) begin
                n_err++;
                $display("FAIL basic_rand in=%h: got d=%h dep=%0d e=%b lat=%0d want %h %0d %b %0d",
                         d, od, odep, oe, lat, ecls, edep, eerr, edep + 2);
            end
        end
    endtask

    task automatic test_cfg_busy();
        logic [c_OUT_W-1:0] od;
        logic [3:0] odep;
        logic oe;
        int lat;
        bit st, rl, ra;
        inj_cyc = 1; inj_addr = 6'd2; inj_data = 17'h10001;
        do_walk(11'h040, 0, od, odep, oe, lat, st, rl, ra);
        inj_cyc = -1;
        n_vec++;
        if (od !== 11'h03F) begin
            n_err++;
            $display("FAIL cfg_busy_walk: got %h want 03f", od);
        end
        do_walk(11'h040, 0, od, odep, oe, lat, st, rl, ra);
        n_vec++;
        if (od !== 11'h03F) begin
            n_err++;
            $display("FAIL cfg_busy_dropped: got %h want 03f", od);
        end
        cfg_write(6'd2, 17'h10001);
        do_walk(11'h040, 0, od, odep, oe, lat, st, rl, ra);
        n_vec++;
        if (od !== 11'h001) begin
            n_err++;
            $display("FAIL cfg_idle_write: got %h want 001", od);
        end
        inj_cyc = 0; inj_addr = 6'd2; inj_data = 17'h1003F;
        do_walk(11'h040, 0, od, odep, oe, lat, st, rl, ra);
        inj_cyc = -1;
        mdl[2] = 17'h1003F;
        n_vec++;
        if (od !== 11'h03F) begin
            n_err++;
            $display("FAIL cfg_with_accept: got %h want 03f", od);
        end
    endtask

    task automatic test_backpressure();
        logic [c_OUT_W-1:0] od;
        logic [3:0] odep;
        logic oe;
        int lat;
        bit st, rl, ra;
        do_walk(11'h000, 10, od, odep, oe, lat, st, rl, ra);
        n_vec++;
        if (od !== 11'h0FF || odep !== 4'd1 || lat != 3) begin
            n_err++;
            $display("FAIL bp_result: got d=%h dep=%0d lat=%0d want 0ff 1 3", od, odep, lat);
        end
        n_vec++;
        if (st !== 1'b1 || rl !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold: got stable=%b ready_low=%b want 1 1", st, rl);
        end
        n_vec++;
        if (ra !== 1'b1) begin
            n_err++;
            $display("FAIL bp_no_same_cycle_accept: got in_ready=%b after handshake want 1", ra);
        end
    endtask

    task automatic load_tree();
        int feat [4] = '{6, 1, 7, 5};
        for (int i = 0; i < 15; i++) begin
            int lvl;
            lvl = (i < 1) ? 0 : (i < 3) ? 1 : (i < 7) ? 2 : 3;
            cfg_write(6'(i), {1'b0, 4'(feat[lvl]), 6'(2*i + 2), 6'(2*i + 1)});
        end
        for (int j = 0; j < 16; j++) begin
            cfg_write(6'(15 + j), {1'b1, 5'd0, tree_class(j)});
        end
    endtask

    task automatic test_full_tree();
        logic [c_OUT_W-1:0] od, g;
        logic [3:0] odep;
        logic oe;
        int lat;
        bit st, rl, ra;
        load_tree();
        for (int v = 0; v < 2048; v++) begin
            g = tree_gold(c_IN_W'(v));
            do_walk(c_IN_W'(v), 0, od, odep, oe, lat, st, rl, ra);
            n_vec++;
            if (od !== g || odep !== 4'd4 || oe !== 1'b0 || lat != 6) begin
                n_err++;
                $display("FAIL tree in=%h: got d=%h dep=%0d e=%b lat=%0d want %h 4 0 6",
                         v, od, odep, oe, lat, g);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [c_IN_W-1:0] d;
        int acc [$];
        logic [c_OUT_W-1:0] got [$];
        d = c_IN_W'($urandom);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_ready) acc.push_back(c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
        n_vec++;
        if (acc.size() < 5 || got.size() < 4) begin
            n_err++;
            $display("FAIL b2b_count: got accepts=%0d results=%0d want >=5 >=4", acc.size(), got.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            n_vec++;
            if (acc[i] - acc[i-1] != 7) begin
                n_err++;
                $display("FAIL b2b_period: got %0d want 7", acc[i] - acc[i-1]);
            end
        end
        for (int i = 0; i < got.size(); i++) begin
            n_vec++;
            if (got[i] !== tree_gold(d)) begin
                n_err++;
                $display("FAIL b2b_data: got %h want %h", got[i], tree_gold(d));
            end
        end
    endtask

    task automatic test_reset_midwalk();
        logic [c_OUT_W-1:0] od;
        logic [3:0] odep;
        logic oe;
        int lat;
        bit st, rl, ra, quiet;
        logic [c_IN_W-1:0] d;
        @(negedge clk);
        in_valid = 1'b1; in_data = c_IN_W'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_depth !== 4'd0 || out_err !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midwalk_reset: got v=%b d=%h dep=%0d e=%b busy=%b rdy=%b want 0 0 0 0 0 1",
                     out_valid, out_data, out_depth, out_err, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        n_vec++;
        if (quiet !== 1'b1) begin
            n_err++;
            $display("FAIL midwalk_stale: got stale activity=%b want 0", !quiet);
        end
        d = c_IN_W'($urandom);
        do_walk(d, 0, od, odep, oe, lat, st, rl, ra);
        n_vec++;
        if (od !== tree_gold(d) || odep !== 4'd4 || lat != 6) begin
            n_err++;
            $display("FAIL midwalk_retained in=%h: got d=%h dep=%0d lat=%0d want %h 4 6",
                     d, od, odep, lat, tree_gold(d));
        end
    endtask

    task automatic test_loop_abort();
        logic [c_OUT_W-1:0] od;
        logic [3:0] odep;
        logic oe;
        int lat;
        bit st, rl, ra;
        cfg_write(6'd0, 17'h00000);
        for (int i = 0; i < 3; i++) begin
            do_walk(c_IN_W'($urandom), 0, od, odep, oe, lat, st, rl, ra);
            n_vec++;
            if (od !== '0 || odep !== 4'd8 || oe !== 1'b1 || lat != 10) begin
                n_err++;
                $display("FAIL loop_abort: got d=%h dep=%0d e=%b lat=%0d want 000 8 1 10", od, odep, oe, lat);
            end
        end
    endtask

    task automatic test_random_tables();
        logic [c_OUT_W-1:0] od, ecls;
        logic [3:0] odep;
        logic oe, eerr;
        int lat, edep;
        bit st, rl, ra;
        for (int t = 0; t < 3; t++) begin
            for (int a = 0; a < 64; a++) cfg_write(6'(a), c_EW'($urandom));
            for (int i = 0; i < 30; i++) begin
                logic [c_IN_W-1:0] d;
                d = c_IN_W'($urandom);
                model_walk(d, ecls, edep, eerr);
                do_walk(d, 0, od, odep, oe, lat, st, rl, ra);
                n_vec++;
                if (od !== ecls || odep !== 4'(edep) || oe !== eerr || lat != edep + 2) begin
                    n_err++;
                    $display("FAIL rand_table in=%h: got d=%h dep=%0d e=%b lat=%0d want %h %0d %b %0d",
                             d, od, odep, oe, lat, ecls, edep, eerr, edep + 2);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int a = 0; a < 64; a++) mdl[a] = '0;
        test_reset();
        test_basic();
        test_cfg_busy();
        test_backpressure();
        test_full_tree();
        test_back_to_back();
        test_reset_midwalk();
        test_loop_abort();
        test_random_tables();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
